// File: rtl/fetch_unit_if.sv
// Instruction-bus read handshake between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if #(
  parameter int unsigned PcW = 12
);
  logic           cyc;
  logic           stb;
  logic [PcW-1:0] adr;
  logic           ack;
  logic [17:0]    dat;

  modport master (
    output cyc, stb, adr,
    input  ack, dat
  );

  modport slave (
    input  cyc, stb, adr,
    output ack, dat
  );
endinterface

// File: rtl/fetch_unit.sv
// Gumnut instruction-fetch stage: program counter, return-address stack, saved interrupt PC
// and the instruction-bus read FSM feeding the datapath IR.
module fetch_unit #(
  parameter int unsigned   PcW        = 12,
  parameter int unsigned   StackDepth = 8,
  parameter logic [PcW-1:0] ResetPc   = '0,
  parameter logic [PcW-1:0] IntVec    = PcW'(1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              fetch_c,
  input  logic              pc_upd_c,
  input  logic [2:0]        pc_op_c,
  input  logic [7:0]        disp,
  input  logic [PcW-1:0]    addr,
  fetch_unit_if.master      bus,
  output logic              inst_ack,
  output logic [17:0]       inst_dat,
  output logic              busy,
  output logic [PcW-1:0]    pc,
  output logic              stk_err
);

  localparam int unsigned   SpW      = $clog2(StackDepth);
  localparam logic [SpW:0]  DepthCnt = (SpW+1)'(StackDepth);
  localparam logic [PcW-1:0] PcOne   = PcW'(1);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  typedef enum logic [2:0] {
    OpNop0, OpBranch, OpJump, OpJsb, OpRet, OpInt, OpReti, OpNop7
  } pc_op_e;

  state_e           state_q;
  logic [PcW-1:0]   pc_q;
  logic [PcW-1:0]   int_pc_q;
  logic [PcW-1:0]   stk_mem [StackDepth];
  logic [SpW-1:0]   sp_q;
  logic [SpW:0]     cnt_q;
  logic             stk_err_q;
  logic             cyc_q;
  logic             stb_q;
  logic [PcW-1:0]   adr_q;
  logic             inst_ack_q;
  logic [17:0]      inst_dat_q;

  logic [SpW-1:0]   sp_dec;
  logic [PcW-1:0]   disp_ext;
  pc_op_e           op;

  always_comb begin
    sp_dec   = sp_q - SpW'(1);
    disp_ext = {{(PcW-8){disp[7]}}, disp};
    op       = pc_op_e'(pc_op_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= ResetPc;
      int_pc_q   <= '0;
      sp_q       <= '0;
      cnt_q      <= '0;
      stk_err_q  <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      adr_q      <= '0;
      inst_ack_q <= 1'b0;
      inst_dat_q <= '0;
    end else if (clk_en) begin
      unique case (state_q)
        StIdle: begin
          inst_ack_q <= 1'b0;
          if (fetch_c) begin
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            adr_q   <= pc_q;
            state_q <= StBus;
          end
          // PC commands are only honoured while no fetch is outstanding.
          if (pc_upd_c) begin
            unique case (op)
              OpBranch: pc_q <= pc_q + disp_ext;
              OpJump:   pc_q <= addr;
              OpJsb: begin
                stk_mem[sp_q] <= pc_q;
                sp_q          <= sp_q + SpW'(1);
                pc_q          <= addr;
                if (cnt_q == DepthCnt) stk_err_q <= 1'b1;
                else                   cnt_q     <= cnt_q + 1'b1;
              end
              OpRet: begin
                pc_q <= stk_mem[sp_dec];
                sp_q <= sp_dec;
                if (cnt_q == '0) stk_err_q <= 1'b1;
                else             cnt_q     <= cnt_q - 1'b1;
              end
              OpInt: begin
                int_pc_q <= pc_q;
                pc_q     <= IntVec;
              end
              OpReti:          pc_q <= int_pc_q;
              OpNop0, OpNop7:  ;
              default:         ;
            endcase
          end
        end
        StBus: begin
          if (bus.ack) begin
            inst_dat_q <= bus.dat;
            inst_ack_q <= 1'b1;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            pc_q       <= pc_q + PcOne;
            state_q    <= StDone;
          end
        end
        StDone: begin
          inst_ack_q <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cyc  = cyc_q;
  assign bus.stb  = stb_q;
  assign bus.adr  = adr_q;
  assign inst_ack = inst_ack_q;
  assign inst_dat = inst_dat_q;
  assign busy     = (state_q != StIdle);
  assign pc       = pc_q;
  assign stk_err  = stk_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch handshake, PC ops, stack wrap and reset/enable corners.
module tb_fetch_unit;

  localparam int unsigned PcW = 12;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clk_en;
  logic           fetch_c;
  logic           pc_upd_c;
  logic [2:0]     pc_op_c;
  logic [7:0]     disp;
  logic [PcW-1:0] addr;
  logic           inst_ack;
  logic [17:0]    inst_dat;
  logic           busy;
  logic [PcW-1:0] pc;
  logic           stk_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];

  fetch_unit_if #(.PcW(PcW)) bus ();

  fetch_unit #(.PcW(PcW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .fetch_c  (fetch_c),
    .pc_upd_c (pc_upd_c),
    .pc_op_c  (pc_op_c),
    .disp     (disp),
    .addr     (addr),
    .bus      (bus),
    .inst_ack (inst_ack),
    .inst_dat (inst_dat),
    .busy     (busy),
    .pc       (pc),
    .stk_err  (stk_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pc_cmd(input logic [2:0] op, input logic [PcW-1:0] a, input logic [7:0] d);
    pc_upd_c = 1'b1;
    pc_op_c  = op;
    addr     = a;
    disp     = d;
    step();
    pc_upd_c = 1'b0;
  endtask

  // Wait (bounded) for inst_ack with the bus acking, then check against the scoreboard.
  task automatic wait_ack(input string tag);
    bit seen = 1'b0;
    logic [17:0] exp;
    for (int i = 0; i < 16 && !seen; i++) begin
      step();
      if (inst_ack) seen = 1'b1;
    end
    bus.ack = 1'b0;
    chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    if (seen && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk({tag, "_dat"}, 32'(inst_dat), 32'(exp));
    end
  endtask

  task automatic fetch(input string tag, input logic [17:0] d, input int waits);
    exp_q.push_back(d);
    fetch_c = 1'b1;
    step();
    fetch_c = 1'b0;
    repeat (waits) step();
    bus.ack = 1'b1;
    bus.dat = d;
    wait_ack(tag);
    step();
    chk({tag, "_ack_pulse"}, 32'(inst_ack), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; fetch_c = 1'b0; pc_upd_c = 1'b0;
    pc_op_c = 3'd0; disp = 8'h00; addr = '0;
    bus.ack = 1'b0; bus.dat = '0;
    step(); step();
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_cyc", 32'(bus.cyc), 32'd0);
    chk("rst_ack", 32'(inst_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(stk_err), 32'd0);
    rst_n = 1'b1;

    // First fetch with two wait states: address held for three cycles.
    exp_q.push_back(18'h2ABCD);
    fetch_c = 1'b1;
    step();
    fetch_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("f1_cyc", 32'({bus.cyc, bus.stb}), 32'b11);
      chk("f1_adr", 32'(bus.adr), 32'h000);
      chk("f1_ack_early", 32'(inst_ack), 32'd0);
      if (i < 2) step();
    end
    bus.ack = 1'b1; bus.dat = 18'h2ABCD;
    wait_ack("f1");
    chk("f1_cyc_done", 32'(bus.cyc), 32'd0);
    chk("f1_pc", 32'(pc), 32'h001);
    chk("f1_busy_done", 32'(busy), 32'd1);
    step();
    chk("f1_ack_pulse", 32'(inst_ack), 32'd0);
    chk("f1_idle", 32'(busy), 32'd0);

    // Branch arithmetic, including wrap.
    pc_cmd(3'd2, 12'h010, 8'h00);
    pc_cmd(3'd1, 12'h000, 8'hFE);
    chk("br_back", 32'(pc), 32'h00E);
    pc_cmd(3'd2, 12'hFFF, 8'h00);
    pc_cmd(3'd1, 12'h000, 8'h02);
    chk("br_wrap", 32'(pc), 32'h001);
    pc_cmd(3'd7, 12'h3CC, 8'h40);
    chk("nop7", 32'(pc), 32'h001);

    // Stack overflow: nine jsb from 0x100; stack then holds 8,1..7 with sp wrapped to 1.
    pc_cmd(3'd2, 12'h100, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      pc_cmd(3'd3, PcW'(i), 8'h00);
      chk("jsb_pc", 32'(pc), 32'(i));
      chk("jsb_err", 32'(stk_err), (i == 9) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      pc_cmd(3'd4, 12'h000, 8'h00);
      chk("ret_pc", 32'(pc), 32'(8 - i));
    end
    pc_cmd(3'd4, 12'h000, 8'h00);
    chk("ret_stale", 32'(pc), 32'h008);
    chk("ret_err", 32'(stk_err), 32'd1);

    // Interrupt entry and return.
    pc_cmd(3'd2, 12'h055, 8'h00);
    pc_cmd(3'd5, 12'h000, 8'h00);
    chk("int_pc", 32'(pc), 32'h001);
    pc_cmd(3'd6, 12'h000, 8'h00);
    chk("reti_pc", 32'(pc), 32'h055);

    // Jump during BUS is ignored; fetch then completes normally.
    exp_q.push_back(18'h1F00F);
    fetch_c = 1'b1;
    step();
    fetch_c = 1'b0;
    pc_cmd(3'd2, 12'h3AA, 8'h00);
    chk("busy_jump", 32'(pc), 32'h055);
    chk("busy_adr", 32'(bus.adr), 32'h055);
    bus.ack = 1'b1; bus.dat = 18'h1F00F;
    wait_ack("f2");
    chk("f2_pc", 32'(pc), 32'h056);
    step();

    // Reset in the middle of a bus cycle abandons the fetch.
    fetch_c = 1'b1;
    step();
    fetch_c = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mid_rst_cyc", 32'({bus.cyc, bus.stb}), 32'b00);
    chk("mid_rst_pc", 32'(pc), 32'h000);
    chk("mid_rst_ack", 32'(inst_ack), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ack", 32'(inst_ack), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Clock enable low freezes a pending bus cycle even with ack asserted.
    exp_q.push_back(18'h0C3A5);
    fetch_c = 1'b1;
    step();
    fetch_c = 1'b0;
    clk_en = 1'b0;
    bus.ack = 1'b1; bus.dat = 18'h0C3A5;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("en_hold_cyc", 32'(bus.cyc), 32'd1);
      chk("en_hold_ack", 32'(inst_ack), 32'd0);
      chk("en_hold_pc", 32'(pc), 32'h000);
    end
    clk_en = 1'b1;
    wait_ack("f3");
    chk("f3_pc", 32'(pc), 32'h001);
    step();

    // Back-to-back zero-wait fetch after all that.
    fetch("f4", 18'h3FFFF, 0);
    chk("f4_pc", 32'(pc), 32'h002);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
